// File: rtl/disp_scan_ctrl_if.sv
// Host-side write/commit bus for the display scan controller.
// The host drives the shadow-buffer writes and commit requests; the controller returns commit_ack.
interface disp_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       commit;
  logic       commit_ack;

  modport master (
    output wr_en, wr_addr, wr_data, wr_dp, commit,
    input  commit_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_dp, commit,
    output commit_ack
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Multiplexed hex display scan scheduler: per-digit dwell slots with leading blanking,
// and a shadow/active double buffer that swaps only at a frame boundary.
module disp_scan_ctrl #(
  parameter int DVSR       = 120000,
  parameter int BLANK_CYC  = 1200,
  parameter int NUM_DIGITS = 6
) (
  input  logic                  CLK_12_MHZ,
  input  logic                  RST_N,
  disp_scan_ctrl_if.slave       bus,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [3:0]            hex,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam logic [22:0]           CNT_LAST  = 23'(DVSR - 1);
  localparam logic [22:0]           BLANK_END = 23'(BLANK_CYC - 1);
  localparam logic [2:0]            IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = NUM_DIGITS'(1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t      state, state_next;
  logic [22:0] cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic        pending;

  // Each entry is {dp, hex}; sized to the full 3-bit address space so indexing is exact.
  logic [4:0] shadow [8];
  logic [4:0] active [8];

  logic                  slot_wrap;
  logic                  frame_end;
  logic                  do_load;
  logic                  addr_ok;
  logic [NUM_DIGITS-1:0] an_n_next;
  logic [3:0]            hex_next;
  logic                  dp_next;
  logic                  frame_tick_next;

  assign slot_wrap = (cnt == CNT_LAST);
  assign frame_end = slot_wrap && (idx == IDX_LAST);
  assign do_load   = frame_end && (pending || bus.commit);
  assign addr_ok   = ({1'b0, bus.wr_addr} < 4'(NUM_DIGITS));

  // Outputs are registered from next-cycle values so each registered output lines up
  // with the cnt/idx/state of the same cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latch).
    cnt_next        = slot_wrap ? '0 : cnt + 23'd1;
    idx_next        = idx;
    state_next      = state;
    an_n_next       = '1;
    hex_next        = 4'h0;
    dp_next         = 1'b0;

    if (slot_wrap) idx_next = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;

    case (state)
      BLANK:   if (cnt == BLANK_END) state_next = DRIVE;
      DRIVE:   if (slot_wrap)        state_next = BLANK;
      default:                       state_next = BLANK;
    endcase

    // active never changes inside a slot: it only reloads on the frame wrap, which enters BLANK.
    if (state_next == DRIVE) begin
      an_n_next           = ~(ONE_HOT0 << idx_next);
      {dp_next, hex_next} = active[idx_next];
    end

    frame_tick_next = (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
  end

  always_ff @(posedge CLK_12_MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state          <= BLANK;
      cnt            <= '0;
      idx            <= '0;
      pending        <= 1'b0;
      an_n           <= '1;
      hex            <= 4'h0;
      dp             <= 1'b0;
      frame_tick     <= 1'b0;
      bus.commit_ack <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state          <= state_next;
      cnt            <= cnt_next;
      idx            <= idx_next;
      an_n           <= an_n_next;
      hex            <= hex_next;
      dp             <= dp_next;
      frame_tick     <= frame_tick_next;
      bus.commit_ack <= do_load;
      if (do_load)         pending <= 1'b0;
      else if (bus.commit) pending <= 1'b1;
    end
  end

  // NOTE: the buffers are small register arrays that must read as zero after reset, so they are reset explicitly.
  always_ff @(posedge CLK_12_MHZ or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      // The copy reads shadow before this edge's write lands, so a boundary-cycle write waits for the next commit.
      if (do_load) begin
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
      end
      if (bus.wr_en && addr_ok) shadow[bus.wr_addr] <= {bus.wr_dp, bus.wr_data};
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with small parameters; every cycle is compared
// against an expected scan pattern plus hand-computed spot checks.
module tb_disp_scan_ctrl;
  localparam int DVSR       = 10;
  localparam int BLANK_CYC  = 2;
  localparam int NUM_DIGITS = 3;
  localparam int FRAME      = DVSR * NUM_DIGITS;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_DIGITS-1:0] an_n;
  logic [3:0]            hex;
  logic                  dp;
  logic                  frame_tick;

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(
    .DVSR(DVSR), .BLANK_CYC(BLANK_CYC), .NUM_DIGITS(NUM_DIGITS)
  ) dut (
    .CLK_12_MHZ(clk),
    .RST_N     (rst_n),
    .bus       (bus),
    .an_n      (an_n),
    .hex       (hex),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int ack_count = 0;
  int last_ack  = -1;

  logic [4:0] m_shadow [NUM_DIGITS];
  logic [4:0] m_active [NUM_DIGITS];
  logic       m_pending;
  logic       m_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_DIGITS; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_pending = 1'b0;
    m_ack     = 1'b0;
    ack_count = 0;
    last_ack  = -1;
    cyc       = 0;
  endtask

  // Called at a falling edge: check this cycle's outputs, advance the expected state
  // across the next rising edge, then clear one-cycle inputs.
  task automatic step();
    int                    cnt;
    int                    d;
    logic                  drive;
    logic                  load;
    logic [NUM_DIGITS-1:0] one;
    logic [NUM_DIGITS-1:0] e_an;
    one   = 1;
    cnt   = cyc % DVSR;
    d     = (cyc / DVSR) % NUM_DIGITS;
    drive = (cnt >= BLANK_CYC);
    e_an  = drive ? ~(one << d) : '1;
    check("an_n",       32'(an_n),           32'(e_an));
    check("hex",        32'(hex),            drive ? 32'(m_active[d][3:0]) : 32'h0);
    check("dp",         32'(dp),             drive ? 32'(m_active[d][4]) : 32'h0);
    check("frame_tick", 32'(frame_tick),     32'((cyc % FRAME) == FRAME - 1));
    check("commit_ack", 32'(bus.commit_ack), 32'(m_ack));
    if (bus.commit_ack === 1'b1) begin
      ack_count++;
      last_ack = cyc;
    end
    load  = ((cyc % FRAME) == FRAME - 1) && (m_pending || bus.commit);
    m_ack = load;
    if (load) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end else if (bus.commit) begin
      m_pending = 1'b1;
    end
    if (bus.wr_en && (int'(bus.wr_addr) < NUM_DIGITS))
      m_shadow[int'(bus.wr_addr)] = {bus.wr_dp, bus.wr_data};
    @(negedge clk);
    cyc++;
    bus.wr_en  = 1'b0;
    bus.commit = 1'b0;
    bus.wr_dp  = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic write_digit(input int a, input logic [3:0] v, input logic p);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_data = v;
    bus.wr_dp   = p;
    step();
  endtask

  task automatic commit_now();
    bus.commit = 1'b1;
    step();
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      check("rst_an_n",       32'(an_n),           32'h7);
      check("rst_hex",        32'(hex),            32'h0);
      check("rst_dp",         32'(dp),             32'h0);
      check("rst_frame_tick", 32'(frame_tick),     32'h0);
      check("rst_commit_ack", 32'(bus.commit_ack), 32'h0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_dp   = 1'b0;
    bus.commit  = 1'b0;
    model_clear();
    @(negedge clk);

    // Reset, then writes with no commit: display stays dark-zero for two frames.
    apply_reset(5);
    write_digit(0, 4'hA, 1'b0);
    write_digit(1, 4'h5, 1'b0);
    write_digit(2, 4'hF, 1'b0);
    run_to(12);
    check("scan_digit1_an", 32'(an_n), 32'h5);
    run_to(60);
    check("no_commit_no_ack", 32'(ack_count), 32'd0);

    // Commit mid-frame: ack on the first cycle of the next frame, values visible from its first drive cycle.
    apply_reset(2);
    write_digit(0, 4'hA, 1'b0);
    write_digit(1, 4'h5, 1'b0);
    write_digit(2, 4'hF, 1'b0);
    run_to(7);
    commit_now();
    run_to(31);
    check("ack_at_30", 32'(last_ack), 32'd30);
    run_to(35);
    check("f1_digit0", 32'(hex), 32'hA);
    run_to(45);
    check("f1_digit1", 32'(hex), 32'h5);
    run_to(55);
    check("f1_digit2", 32'(hex), 32'hF);

    // Commit plus write on the boundary cycle: old value copied, the new one needs another commit.
    run_to(59);
    bus.commit  = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 4'h3;
    step();
    check("bnd_ack_next", 32'(bus.commit_ack), 32'h1);
    run_to(65);
    check("bnd_old_value", 32'(hex), 32'hA);
    commit_now();
    run_to(95);
    check("bnd_new_value", 32'(hex), 32'h3);
    check("bnd_second_ack", 32'(last_ack), 32'd90);

    // Out-of-range address is dropped; decimal point tracks only its own digit.
    run_to(100);
    write_digit(3, 4'h7, 1'b0);
    commit_now();
    run_to(125);
    check("oor_digit0", 32'(hex), 32'h3);
    run_to(135);
    check("oor_digit1", 32'(hex), 32'h5);
    write_digit(1, 4'h5, 1'b1);
    commit_now();
    run_to(155);
    check("dp_digit0", 32'(dp), 32'h0);
    run_to(165);
    check("dp_digit1", 32'(dp), 32'h1);
    run_to(175);
    check("dp_digit2", 32'(dp), 32'h0);

    // Reset mid-frame drops the pending commit and restarts the scan from digit 0.
    apply_reset(2);
    write_digit(0, 4'h9, 1'b1);
    run_to(5);
    commit_now();
    run_to(15);
    apply_reset(1);
    run_to(2);
    check("restart_digit0_an", 32'(an_n), 32'h6);
    run_to(60);
    check("restart_no_ack", 32'(ack_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
